// File: rtl/ins_loader_pkg.sv
// Shared types and helpers for the host instruction loader.
package ins_loader_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    localparam int BYTES_PER_WORD = 4;

    // Byte index 0 lands in bits [31:24]: the host sends MSB first.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[(BYTES_PER_WORD - 1 - int'(idx)) * 8 +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/ins_loader_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses taken from the synchronized signal.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ins_loader.sv
// Assembles host bytes (STB/ACK handshake, MSB first) into 32-bit words and
// writes them to instruction memory at an auto-incrementing word address.
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        DIN,
    input  logic              STB,
    input  logic              START,
    output logic              ACK,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [ADDR_W:0]   WCOUNT,
    output logic              BUSY,
    output logic              ERR
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] WCOUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic stb_rise, stb_fall, start_rise;

    edge_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk(CLK), .rst(RST), .d(STB), .rise(stb_rise), .fall(stb_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_start_sync (
        .clk(CLK), .rst(RST), .d(START), .rise(start_rise), .fall()
    );

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       w_ins_q, w_ins_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wcount_q, wcount_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              pend_q, pend_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       shift_nxt;
    logic              capture;

    // A rise while the previous byte is still acknowledged is a host error.
    assign capture   = stb_rise & ~ack_q;
    assign shift_nxt = put_byte(shift_q, idx_q, DIN);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        w_ins_d  = w_ins_q;
        addr_d   = addr_q;
        wcount_d = wcount_q;
        err_d    = err_q;
        ack_d    = ack_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;

        if (stb_fall) ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                tmo_d = '0;
                if (start_rise || pend_q) begin
                    shift_d  = '0;
                    addr_d   = '0;
                    wcount_d = '0;
                    err_d    = 1'b0;
                    ack_d    = 1'b0;
                    pend_d   = 1'b0;
                end else if (capture) begin
                    shift_d = put_byte('0, 2'd0, DIN);
                    idx_d   = 2'd1;
                    ack_d   = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (start_rise) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    tmo_d    = '0;
                    shift_d  = '0;
                    addr_d   = '0;
                    wcount_d = '0;
                    err_d    = 1'b0;
                    ack_d    = 1'b0;
                end else if (capture) begin
                    shift_d = shift_nxt;
                    ack_d   = 1'b1;
                    tmo_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        w_ins_d = shift_nxt;
                        idx_d   = '0;
                        state_d = COMMIT;
                    end
                end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tmo_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                addr_d  = addr_q + 1'b1;
                if (addr_q == {ADDR_W{1'b1}}) err_d = 1'b1;
                if (wcount_q != WCOUNT_MAX) wcount_d = wcount_q + 1'b1;
                // A START seen mid-commit is honoured once the write is done.
                if (start_rise) pend_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shift_q  <= '0;
            w_ins_q  <= '0;
            addr_q   <= '0;
            wcount_q <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            w_ins_q  <= w_ins_d;
            addr_q   <= addr_d;
            wcount_q <= wcount_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
        end
    end

    assign ACK    = ack_q;
    assign W_Ins  = w_ins_q;
    assign WE     = (state_q == COMMIT);
    assign W_ADDR = addr_q;
    assign WCOUNT = wcount_q;
    assign BUSY   = (state_q != IDLE);
    assign ERR    = err_q;

endmodule
